// File: rtl/ctrl_riesgos_pipeline.sv
// Hazard/stall controller for a 5-stage MIPS pipeline: load-use bubbles, branch flushes,
// data-memory wait states with a timeout watchdog, and a saturating stall-cycle counter.
module ctrl_riesgos_pipeline #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             usa_rt_id,
    input  logic [4:0]       rt_ex,
    input  logic             mem_rd_ex,
    input  logic             salto_mem,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WcntW = $clog2(TIMEOUT + 1);
    localparam logic [WcntW-1:0] TimeoutW = WcntW'(TIMEOUT);
    localparam logic [WcntW-1:0] OneW     = WcntW'(1);

    typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

    state_e             state_q, state_d;
    logic [WcntW-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               mem_stall, load_use;

    assign mem_stall = mem_req & ~mem_ack;
    assign load_use  = mem_rd_ex && (rt_ex != 5'd0) &&
                       ((rt_ex == rs_id) || (usa_rt_id && (rt_ex == rt_id)));

    // Outputs are zero-latency; S_MEMWAIT exit cycles fall through to the S_RUN priorities.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        if (reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (state_q == StErr || mem_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (salto_mem) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    wcnt_d  = OneW;
                    state_d = (TIMEOUT <= 1) ? StErr : StMemWait;
                end
            end
            StMemWait: begin
                if (mem_stall) begin
                    wcnt_d = wcnt_q + OneW;
                    if (wcnt_d >= TimeoutW) state_d = StErr;
                end else begin
                    wcnt_d  = '0;
                    state_d = StRun;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign err_timeout = ~reset & (state_q == StErr);
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_riesgos_pipeline.sv
// Self-checking bench: vector table plus timeout sequence, expectations queued at drive time
// and compared when outputs are sampled on the falling edge.
module tb_ctrl_riesgos_pipeline;

    // Output pattern bits: {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, bubble}
    localparam logic [7:0] ORun = 8'b1101_0100;
    localparam logic [7:0] OFrz = 8'b0000_0001;
    localparam logic [7:0] OLu  = 8'b0001_1100;
    localparam logic [7:0] OBr  = 8'b1111_1110;
    localparam logic [7:0] ORst = 8'b0010_1011;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt;
        logic       usa;
        logic [4:0] rtex;
        logic       mrd, salto, req, ack;
        logic [7:0] outs;
        logic       chk_cnt;
    } vec_t;

    typedef struct {
        logic [7:0]  outs;
        logic        err;
        logic [15:0] cnt;
        logic        chk_cnt;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, usa_rt_id, mem_rd_ex, salto_mem, mem_req, mem_ack;
    logic [4:0]  rs_id, rt_id, rt_ex;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;
    logic        memwb_bubble, err_timeout;
    logic [15:0] stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;
    exp_t        sb[$];
    vec_t        tbl[22];

    always #5 clk = ~clk;

    ctrl_riesgos_pipeline #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .usa_rt_id    (usa_rt_id),
        .rt_ex        (rt_ex),
        .mem_rd_ex    (mem_rd_ex),
        .salto_mem    (salto_mem),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .exmem_flush  (exmem_flush),
        .memwb_bubble (memwb_bubble),
        .err_timeout  (err_timeout),
        .stall_cnt    (stall_cnt)
    );

    function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic usa,
                                logic [4:0] rtex, logic mrd, logic salto, logic req,
                                logic ack, logic [7:0] outs, logic chk_cnt);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.usa = usa; v.rtex = rtex; v.mrd = mrd;
        v.salto = salto; v.req = req; v.ack = ack; v.outs = outs; v.chk_cnt = chk_cnt;
        return v;
    endfunction

    task automatic step(input vec_t v, input logic exp_err, input int id);
        exp_t        e;
        logic [7:0]  got;
        @(posedge clk);
        #1;
        reset = v.rst; rs_id = v.rs; rt_id = v.rt; usa_rt_id = v.usa; rt_ex = v.rtex;
        mem_rd_ex = v.mrd; salto_mem = v.salto; mem_req = v.req; mem_ack = v.ack;
        sb.push_back('{outs: v.outs, err: exp_err, cnt: exp_cnt, chk_cnt: v.chk_cnt, id: id});
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard[%0d] empty queue", id);
            return;
        end
        e   = sb.pop_front();
        got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
               memwb_bubble};
        if (got !== e.outs) begin
            errors++;
            $display("FAIL outs[%0d] got %b want %b", e.id, got, e.outs);
        end
        checks++;
        if (err_timeout !== e.err) begin
            errors++;
            $display("FAIL err_timeout[%0d] got %b want %b", e.id, err_timeout, e.err);
        end
        if (e.chk_cnt) begin
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL stall_cnt[%0d] got %0d want %0d", e.id, stall_cnt, e.cnt);
            end
        end
        if (v.rst) exp_cnt = '0;
        else if (!e.outs[7] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    initial begin
        //             rst rs  rt  usa rtex mrd sal req ack outs  chk
        tbl[0]  = mk(1, 0,  0,  0,  0,  0,  0,  0,  0,  ORst, 0);
        tbl[1]  = mk(1, 0,  0,  0,  0,  0,  0,  0,  0,  ORst, 1);
        tbl[2]  = mk(1, 0,  0,  0,  0,  0,  0,  0,  0,  ORst, 1);
        tbl[3]  = mk(0, 0,  0,  0,  0,  0,  0,  0,  0,  ORun, 1);
        tbl[4]  = mk(0, 5,  1,  0,  5,  1,  0,  0,  0,  OLu,  1);
        tbl[5]  = mk(0, 5,  1,  0,  5,  0,  0,  0,  0,  ORun, 1);
        tbl[6]  = mk(0, 0,  0,  1,  0,  1,  0,  0,  0,  ORun, 1);
        tbl[7]  = mk(0, 3,  7,  1,  7,  1,  0,  0,  0,  OLu,  1);
        tbl[8]  = mk(0, 3,  7,  0,  7,  1,  0,  0,  0,  ORun, 1);
        tbl[9]  = mk(0, 9,  2,  0,  9,  1,  1,  0,  0,  OBr,  1);
        tbl[10] = mk(0, 0,  0,  0,  0,  0,  0,  1,  0,  OFrz, 1);
        tbl[11] = mk(0, 0,  0,  0,  0,  0,  0,  1,  0,  OFrz, 1);
        tbl[12] = mk(0, 0,  0,  0,  0,  0,  0,  1,  0,  OFrz, 1);
        tbl[13] = mk(0, 0,  0,  0,  0,  0,  0,  1,  1,  ORun, 1);
        tbl[14] = mk(0, 0,  0,  0,  0,  0,  0,  1,  1,  ORun, 1);
        tbl[15] = mk(0, 0,  0,  0,  0,  0,  0,  1,  0,  OFrz, 1);
        tbl[16] = mk(0, 0,  0,  0,  0,  0,  1,  0,  0,  OBr,  1);
        tbl[17] = mk(0, 0,  0,  0,  0,  0,  0,  1,  0,  OFrz, 1);
        tbl[18] = mk(0, 0,  0,  0,  0,  0,  0,  1,  0,  OFrz, 1);
        tbl[19] = mk(1, 0,  0,  0,  0,  0,  0,  1,  0,  ORst, 1);
        tbl[20] = mk(0, 0,  0,  0,  0,  0,  0,  1,  1,  ORun, 1);
        tbl[21] = mk(0, 4,  0,  0,  4,  1,  0,  0,  0,  OLu,  1);

        for (int i = 0; i < 22; i++) step(tbl[i], 1'b0, i);

        // Watchdog: 16 stalled cycles, then sticky error that ignores inputs until reset.
        for (int i = 0; i < 16; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, OFrz, 1), 1'b0, 100 + i);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, OFrz, 1), 1'b1, 116);
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, OFrz, 1), 1'b1, 117);
        step(mk(0, 5, 0, 0, 5, 1, 0, 1, 1, OFrz, 1), 1'b1, 118);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, OFrz, 1), 1'b1, 119);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, ORst, 1), 1'b0, 120);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ORun, 1), 1'b0, 121);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, ORun, 1), 1'b0, 122);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
